// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters, allocate-on-taken
// training and saturating branch/mispredict statistics. Define BP_GSHARE_EN for gshare counter indexing.
module branch_target_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] bp_in_f_pc,
    input  logic [XLEN-1:0] bp_in_e_pc,
    input  logic [XLEN-1:0] bp_in_e_pc_branch_target,
    input  logic            bp_in_e_branch_en,
    input  logic            bp_in_e_branch_taken_en,
    input  logic            bp_in_e_branch_mispredict_en,
    output logic            bp_out_f_predicted_en,
    output logic            bp_out_f_predicted_taken_en,
    output logic [XLEN-1:0] bp_out_f_predicted_pc,
    output logic [31:0]     bp_out_branch_count,
    output logic [31:0]     bp_out_mispredict_count
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2 ** (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);

    logic [IDX-1:0]      f_idx, e_idx, f_cidx, e_cidx;
    logic [TAG_BITS-1:0] f_tag, e_tag;
    logic                f_hit, e_hit;

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [XLEN-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    assign f_idx = bp_in_f_pc[IDX+1:2];
    assign e_idx = bp_in_e_pc[IDX+1:2];
    assign f_tag = bp_in_f_pc[IDX+1+TAG_BITS:IDX+2];
    assign e_tag = bp_in_e_pc[IDX+1+TAG_BITS:IDX+2];

    // Low alignment bits and PC bits above the tag take no part in lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp_in_f_pc[1:0], bp_in_f_pc[XLEN-1:IDX+2+TAG_BITS],
                              bp_in_e_pc[1:0], bp_in_e_pc[XLEN-1:IDX+2+TAG_BITS]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    // Training indexes with the pre-shift history, matching what fetch saw.
    assign f_cidx = f_idx ^ IDX'(ghr_q);
    assign e_cidx = e_idx ^ IDX'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (bp_in_e_branch_en) begin
            ghr_d = (ghr_q << 1) | GHR_BITS'(bp_in_e_branch_taken_en);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign f_cidx = f_idx;
    assign e_cidx = e_idx;
`endif

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    // Lookup reads registered state only, so same-cycle training is never forwarded.
    assign bp_out_f_predicted_en       = f_hit;
    assign bp_out_f_predicted_taken_en = f_hit && ctr_q[f_cidx][CTR_BITS-1];
    assign bp_out_f_predicted_pc       = f_hit ? target_q[f_idx] : '0;
    assign bp_out_branch_count         = branch_count_q;
    assign bp_out_mispredict_count     = mispredict_count_q;

    // NOTE: every next-state signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp_in_e_branch_en) begin
            if (e_hit) begin
                if (bp_in_e_branch_taken_en) begin
                    if (ctr_q[e_cidx] != CTR_MAX) begin
                        ctr_d[e_cidx] = ctr_q[e_cidx] + CTR_BITS'(1);
                    end
                    target_d[e_idx] = bp_in_e_pc_branch_target;
                end else if (ctr_q[e_cidx] != '0) begin
                    ctr_d[e_cidx] = ctr_q[e_cidx] - CTR_BITS'(1);
                end
            end else if (bp_in_e_branch_taken_en) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = bp_in_e_pc_branch_target;
                ctr_d[e_cidx]   = CTR_WT;
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bp_in_e_branch_en) begin
            if (branch_count_q != 32'hFFFF_FFFF) begin
                branch_count_d = branch_count_q + 32'd1;
            end
            if (bp_in_e_branch_mispredict_en && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    // NOTE: sequential state is assigned only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // NOTE: tag and target storage is deliberately not reset; the cleared valid bits mask it on every read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor: expected lookups and statistics
// are queued as each step is driven and compared when the outputs settle.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bp_in_f_pc;
    logic [31:0] bp_in_e_pc;
    logic [31:0] bp_in_e_pc_branch_target;
    logic        bp_in_e_branch_en;
    logic        bp_in_e_branch_taken_en;
    logic        bp_in_e_branch_mispredict_en;
    logic        bp_out_f_predicted_en;
    logic        bp_out_f_predicted_taken_en;
    logic [31:0] bp_out_f_predicted_pc;
    logic [31:0] bp_out_branch_count;
    logic [31:0] bp_out_mispredict_count;

    always #5 clk = ~clk;

    branch_target_predictor dut (
        .clk                          (clk),
        .reset                        (reset),
        .bp_in_f_pc                   (bp_in_f_pc),
        .bp_in_e_pc                   (bp_in_e_pc),
        .bp_in_e_pc_branch_target     (bp_in_e_pc_branch_target),
        .bp_in_e_branch_en            (bp_in_e_branch_en),
        .bp_in_e_branch_taken_en      (bp_in_e_branch_taken_en),
        .bp_in_e_branch_mispredict_en (bp_in_e_branch_mispredict_en),
        .bp_out_f_predicted_en        (bp_out_f_predicted_en),
        .bp_out_f_predicted_taken_en  (bp_out_f_predicted_taken_en),
        .bp_out_f_predicted_pc        (bp_out_f_predicted_pc),
        .bp_out_branch_count          (bp_out_branch_count),
        .bp_out_mispredict_count      (bp_out_mispredict_count)
    );

    typedef struct {
        string       name;
        logic        en;
        logic        tk;
        logic [31:0] pc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_bc = '0;
    logic [31:0] exp_mc = '0;

    task automatic cmp(string name, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, check the settled outputs (state from
    // earlier edges), then advance the statistics model by what the coming rising edge commits.
    task automatic step(string name, logic chk, logic rst, logic [31:0] f_pc, logic br,
                        logic [31:0] e_pc, logic tk, logic [31:0] tgt, logic mp,
                        logic x_en, logic x_tk, logic [31:0] x_pc);
        exp_t e;
        @(negedge clk);
        reset                        = rst;
        bp_in_f_pc                   = f_pc;
        bp_in_e_branch_en            = br;
        bp_in_e_pc                   = e_pc;
        bp_in_e_branch_taken_en      = tk;
        bp_in_e_pc_branch_target     = tgt;
        bp_in_e_branch_mispredict_en = mp;
        if (chk) begin
            e.name = name;
            e.en   = x_en;
            e.tk   = x_tk;
            e.pc   = x_pc;
            e.bc   = exp_bc;
            e.mc   = exp_mc;
            sb.push_back(e);
        end
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp({e.name, ".en"}, 32'(bp_out_f_predicted_en), 32'(e.en));
            cmp({e.name, ".taken"}, 32'(bp_out_f_predicted_taken_en), 32'(e.tk));
            cmp({e.name, ".pc"}, bp_out_f_predicted_pc, e.pc);
            cmp({e.name, ".branch_count"}, bp_out_branch_count, e.bc);
            cmp({e.name, ".mispredict_count"}, bp_out_mispredict_count, e.mc);
        end
        if (rst) begin
            exp_bc = '0;
            exp_mc = '0;
        end else if (br) begin
            if (exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 32'd1;
            if (mp && (exp_mc != 32'hFFFF_FFFF)) exp_mc = exp_mc + 32'd1;
        end
    endtask

    task automatic look(string name, logic [31:0] f_pc, logic x_en, logic x_tk, logic [31:0] x_pc);
        step(name, 1'b1, 1'b0, f_pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, x_en, x_tk, x_pc);
    endtask

    task automatic train(string name, logic [31:0] f_pc, logic [31:0] e_pc, logic tk,
                         logic [31:0] tgt, logic mp, logic x_en, logic x_tk, logic [31:0] x_pc);
        step(name, 1'b1, 1'b0, f_pc, 1'b1, e_pc, tk, tgt, mp, x_en, x_tk, x_pc);
    endtask

    initial begin
        reset                        = 1'b1;
        bp_in_f_pc                   = '0;
        bp_in_e_pc                   = '0;
        bp_in_e_pc_branch_target     = '0;
        bp_in_e_branch_en            = 1'b0;
        bp_in_e_branch_taken_en      = 1'b0;
        bp_in_e_branch_mispredict_en = 1'b0;

        // Reset, with training held during reset that must be discarded.
        step("rst0", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step("rst_train", 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'hDEAD_BEE0, 1'b1,
             1'b0, 1'b0, 32'h0);
        look("post_rst", 32'h100, 1'b0, 1'b0, 32'h0);

`ifdef BP_GSHARE_EN
        // History 00 -> 01 -> 11; lookup then reads counter 0^3 = 3, still weakly not-taken.
        train("g_alloc", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
        train("g_hit", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h80);
        look("g_idx3", 32'h100, 1'b1, 1'b0, 32'h80);
`else
        // Allocate on taken; same-cycle lookup still misses.
        train("t2_same", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
        look("t2_hit", 32'h100, 1'b1, 1'b1, 32'h80);

        // Decrement to the floor; not-taken never changes the target.
        train("t3_nt1", 32'h100, 32'h100, 1'b0, 32'h999, 1'b1, 1'b1, 1'b1, 32'h80);
        train("t3_nt2", 32'h100, 32'h100, 1'b0, 32'h999, 1'b0, 1'b1, 1'b0, 32'h80);
        train("t3_nt3", 32'h100, 32'h100, 1'b0, 32'h999, 1'b0, 1'b1, 1'b0, 32'h80);
        look("t3_floor", 32'h100, 1'b1, 1'b0, 32'h80);

        // Climb to the ceiling and hold there; one not-taken then leaves it weakly taken.
        train("sat_t1", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h80);
        train("sat_t2", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h80);
        train("sat_t3", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 32'h80);
        train("sat_t4", 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 32'h80);
        train("sat_nt", 32'h100, 32'h100, 1'b0, 32'h80, 1'b0, 1'b1, 1'b1, 32'h80);
        look("sat_ceiling", 32'h100, 1'b1, 1'b1, 32'h80);

        // Tag conflict at index 0: no allocation on not-taken, eviction on taken.
        look("t4_alias", 32'h140, 1'b0, 1'b0, 32'h0);
        train("t4_nt_noalloc", 32'h100, 32'h140, 1'b0, 32'h200, 1'b0, 1'b1, 1'b1, 32'h80);
        look("t4_keep", 32'h100, 1'b1, 1'b1, 32'h80);
        train("t4_alloc", 32'h140, 32'h140, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
        look("t4_new", 32'h140, 1'b1, 1'b1, 32'h200);
        look("t4_evicted", 32'h100, 1'b0, 1'b0, 32'h0);

        // Re-allocate 0x100, then a same-cycle retarget shows old contents first.
        train("t5_realloc", 32'h104, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
        train("t5_same", 32'h100, 32'h100, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h80);
        look("t5_next", 32'h100, 1'b1, 1'b1, 32'h300);
        look("t5_low_bits", 32'h103, 1'b1, 1'b1, 32'h300);
        look("other_idx", 32'h104, 1'b0, 1'b0, 32'h0);

        // Mispredict strobe without a branch is ignored; then reset mid-run with training.
        step("t6_mp_nobr", 1'b1, 1'b0, 32'h100, 1'b0, 32'h100, 1'b1, 32'h500, 1'b1,
             1'b1, 1'b1, 32'h300);
        look("t6_counts", 32'h140, 1'b0, 1'b0, 32'h0);
        step("t6_rst", 1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h600, 1'b1,
             1'b1, 1'b1, 32'h300);
        look("t6_after_100", 32'h100, 1'b0, 1'b0, 32'h0);
        look("t6_after_104", 32'h104, 1'b0, 1'b0, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
